// File: rtl/ellipse_quadrant_plotter.sv
`default_nettype none
// ============================================================================
// Module   : ellipse_quadrant_plotter
// Brief    : Buffers generator offsets, mirrors each into up to four clipped
//            screen pixels and streams them out on a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module ellipse_quadrant_plotter #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [11:0] MAX_X      = 12'd639,
    parameter logic [11:0] MAX_Y      = 12'd479
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic signed [11:0] Xc,
    input  logic signed [11:0] Yc,
    input  logic [3:0]         quad_mask,
    input  logic signed [11:0] in_x,
    input  logic signed [11:0] in_y,
    input  logic               in_valid,
    input  logic               in_complete,
    output logic               ena_pause,
    output logic signed [11:0] out_x,
    output logic signed [11:0] out_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    localparam int                    c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]         c_FULL    = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]         c_PAUSE   = (c_AW+1)'(FIFO_DEPTH - 2);
    localparam logic signed [12:0]    c_MAX_X13 = {1'b0, MAX_X};
    localparam logic signed [12:0]    c_MAX_Y13 = {1'b0, MAX_Y};

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_FETCH  = 2'd1;
    localparam logic [1:0] c_S_EMIT   = 2'd2;
    localparam logic [1:0] c_S_FINISH = 2'd3;

    logic [1:0]         r_state, w_next_state;
    logic [23:0]        r_fifo [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic signed [11:0] r_xc, r_yc, r_dx, r_dy;
    logic [3:0]         r_mask, r_emask;
    logic               r_complete, r_overflow;
    logic [11:0]        r_out_x, r_out_y;
    logic               r_out_valid;

    logic               w_full, w_empty, w_push, w_pop, w_start;
    logic               w_slot_free, w_clip, w_emit, w_skip, w_consume;
    logic [1:0]         w_sel;
    logic [3:0]         w_onehot, w_remaining, w_bmask;
    logic [23:0]        w_head;
    logic signed [12:0] w_xc13, w_yc13, w_dx13, w_dy13, w_sx, w_sy;

    assign w_full      = (r_count == c_FULL);
    assign w_empty     = (r_count == '0);
    assign w_start     = start && (r_state == c_S_IDLE);
    assign w_push      = in_valid && busy && !w_full;
    assign w_pop       = (r_state == c_S_FETCH) && !w_empty;
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_head      = r_fifo[r_rd_ptr];

    // Entries on an axis would land on the same pixel twice; drop the mirror.
    always_comb begin
        w_bmask = r_mask;
        if (w_head[23:12] == 12'd0) begin
            if (w_bmask[0]) w_bmask[1] = 1'b0;
            if (w_bmask[3]) w_bmask[2] = 1'b0;
        end
        if (w_head[11:0] == 12'd0) begin
            if (w_bmask[0]) w_bmask[3] = 1'b0;
            if (w_bmask[1]) w_bmask[2] = 1'b0;
        end
    end

    always_comb begin
        w_sel = 2'd3;
        if (r_emask[0])      w_sel = 2'd0;
        else if (r_emask[1]) w_sel = 2'd1;
        else if (r_emask[2]) w_sel = 2'd2;
    end

    assign w_onehot    = 4'b0001 << w_sel;
    assign w_remaining = r_emask & ~w_onehot;

    assign w_xc13 = {r_xc[11], r_xc};
    assign w_yc13 = {r_yc[11], r_yc};
    assign w_dx13 = {r_dx[11], r_dx};
    assign w_dy13 = {r_dy[11], r_dy};
    assign w_sx   = (w_sel == 2'd1 || w_sel == 2'd2) ? (w_xc13 - w_dx13) : (w_xc13 + w_dx13);
    assign w_sy   = (w_sel[1]) ? (w_yc13 - w_dy13) : (w_yc13 + w_dy13);
    assign w_clip = w_sx[12] || w_sy[12] || (w_sx > c_MAX_X13) || (w_sy > c_MAX_Y13);

    assign w_emit    = (r_state == c_S_EMIT) && (|r_emask) && !w_clip && w_slot_free;
    assign w_skip    = (r_state == c_S_EMIT) && (|r_emask) && w_clip;
    assign w_consume = w_emit || w_skip;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_state <= c_S_IDLE;
        else if (enable) r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:   if (start) w_next_state = c_S_FETCH;
            c_S_FETCH: begin
                if (!w_empty)                       w_next_state = c_S_EMIT;
                else if (r_complete && w_slot_free) w_next_state = c_S_FINISH;
            end
            c_S_EMIT: begin
                if (!(|r_emask) || (w_consume && w_remaining == 4'd0))
                    w_next_state = c_S_FETCH;
            end
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != c_S_IDLE);
        done      = (r_state == c_S_FINISH);
        ena_pause = busy && (r_count >= c_PAUSE);
    end

    always_ff @(posedge clk) begin
        if (enable && w_push) r_fifo[r_wr_ptr] <= {in_x, in_y};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_xc        <= '0;
            r_yc        <= '0;
            r_mask      <= '0;
            r_complete  <= 1'b0;
            r_overflow  <= 1'b0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_emask     <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_valid <= 1'b0;
        end else if (enable) begin
            if (w_start) begin
                r_xc       <= Xc;
                r_yc       <= Yc;
                r_mask     <= quad_mask;
                r_complete <= 1'b0;
                r_overflow <= 1'b0;
            end
            if (busy && in_complete)          r_complete <= 1'b1;
            if (busy && in_valid && w_full)   r_overflow <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;

            if (w_pop) begin
                r_dx    <= w_head[23:12];
                r_dy    <= w_head[11:0];
                r_emask <= w_bmask;
            end else if (w_consume) begin
                r_emask <= w_remaining;
            end

            if (w_emit) begin
                r_out_x     <= w_sx[11:0];
                r_out_y     <= w_sy[11:0];
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ellipse_quadrant_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ellipse_quadrant_plotter
// Brief    : Directed scoreboard bench for ellipse_quadrant_plotter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ellipse_quadrant_plotter;

    logic               clk = 1'b0;
    logic               reset, enable, start;
    logic signed [11:0] Xc, Yc, in_x, in_y;
    logic [3:0]         quad_mask;
    logic               in_valid, in_complete, out_ready;
    logic               ena_pause, out_valid, busy, done, overflow;
    logic signed [11:0] out_x, out_y;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_seen = 0;
    logic        prev_stall = 1'b0;
    logic [23:0] sb[$];
    int          cur_xc, cur_yc;
    logic [3:0]  cur_m;

    always #5 clk = ~clk;

    ellipse_quadrant_plotter dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .Xc(Xc), .Yc(Yc), .quad_mask(quad_mask),
        .in_x(in_x), .in_y(in_y), .in_valid(in_valid), .in_complete(in_complete),
        .ena_pause(ena_pause), .out_x(out_x), .out_y(out_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge, then advance to just after the rising edge.
    task automatic cycle();
        logic [23:0] exp;
        @(negedge clk);
        if (done) done_seen++;
        if (prev_stall) check("hold_valid", 32'(out_valid), 32'd1);
        if (out_valid) begin
            exp = (sb.size() != 0) ? sb[0] : 24'hxxxxxx;
            check("pixel", {8'd0, out_x, out_y}, {8'd0, exp});
            if (enable && out_ready && sb.size() != 0) void'(sb.pop_front());
        end
        prev_stall = out_valid && !(out_ready && enable);
        @(posedge clk);
        #1;
    endtask

    task automatic model(input int dx, input int dy);
        logic [3:0] e;
        int sx, sy;
        e = cur_m;
        if (dx == 0) begin
            if (e[0]) e[1] = 1'b0;
            if (e[3]) e[2] = 1'b0;
        end
        if (dy == 0) begin
            if (e[0]) e[3] = 1'b0;
            if (e[1]) e[2] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            if (e[k]) begin
                sx = (k == 1 || k == 2) ? cur_xc - dx : cur_xc + dx;
                sy = (k >= 2) ? cur_yc - dy : cur_yc + dy;
                if (sx >= 0 && sy >= 0 && sx <= 639 && sy <= 479)
                    sb.push_back({sx[11:0], sy[11:0]});
            end
        end
    endtask

    task automatic begin_shape(input int xc, input int yc, input logic [3:0] m);
        cur_xc = xc; cur_yc = yc; cur_m = m;
        Xc = 12'(xc); Yc = 12'(yc); quad_mask = m;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic push(input int dx, input int dy, input bit use_model);
        in_x = 12'(dx); in_y = 12'(dy); in_valid = 1'b1;
        if (use_model) model(dx, dy);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic complete();
        in_complete = 1'b1;
        cycle();
        in_complete = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50 && !out_valid; i++) cycle();
        check(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int base;
        base = done_seen;
        for (int i = 0; i < 400 && done_seen == base; i++) cycle();
        cycle();
        cycle();
        check({tag, "_done_once"}, 32'(done_seen - base), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int sent;
        reset = 1'b1; enable = 1'b1; start = 1'b0;
        Xc = '0; Yc = '0; quad_mask = '0;
        in_x = '0; in_y = '0; in_valid = 1'b0; in_complete = 1'b0; out_ready = 1'b1;
        cycle();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_pause", 32'(ena_pause), 32'd0);
        check("rst_xy", {8'd0, out_x, out_y}, 32'd0);
        reset = 1'b0;
        cycle();

        // Basic four-quadrant fan-out, with a frozen stretch mid-stream.
        out_ready = 1'b0;
        begin_shape(100, 50, 4'hF);
        sb.push_back({12'd103, 12'd52});
        sb.push_back({12'd97,  12'd52});
        sb.push_back({12'd97,  12'd48});
        sb.push_back({12'd103, 12'd48});
        push(3, 2, 1'b0);
        wait_valid("t1_valid");
        enable = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        check("t1_frozen_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        complete();
        wait_done("t1");

        // Axis offsets: duplicate mirrors suppressed; complete with last offset.
        begin_shape(10, 10, 4'hF);
        sb.push_back({12'd10, 12'd15});
        sb.push_back({12'd10, 12'd5});
        sb.push_back({12'd14, 12'd10});
        sb.push_back({12'd6,  12'd10});
        push(0, 5, 1'b0);
        in_x = 12'd4; in_y = 12'd0; in_valid = 1'b1; in_complete = 1'b1;
        cycle();
        in_valid = 1'b0; in_complete = 1'b0;
        wait_done("t2");

        // Negative-X mirrors fall off screen.
        begin_shape(2, 2, 4'hF);
        sb.push_back({12'd7, 12'd3});
        sb.push_back({12'd7, 12'd1});
        push(5, 1, 1'b0);
        complete();
        wait_done("t3");

        // Stalled sink with a generator that honours ena_pause.
        begin_shape(300, 200, 4'hF);
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            if (!ena_pause && sent < 10) begin
                in_x = 12'(sent + 1); in_y = 12'(2 * sent + 1); in_valid = 1'b1;
                model(sent + 1, 2 * sent + 1);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            cycle();
        end
        in_valid = 1'b0;
        check("t4_sent_before_pause", 32'(sent), 32'd7);
        check("t4_pause_high", 32'(ena_pause), 32'd1);
        check("t4_no_overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 200 && sent < 10; c++) begin
            if (!ena_pause) begin
                in_x = 12'(sent + 1); in_y = 12'(2 * sent + 1); in_valid = 1'b1;
                model(sent + 1, 2 * sent + 1);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            cycle();
        end
        in_valid = 1'b0;
        check("t4_all_sent", 32'(sent), 32'd10);
        complete();
        wait_done("t4");
        check("t4_overflow_end", 32'(overflow), 32'd0);

        // Overflow: nine pushes into a full stall, the ninth is dropped.
        begin_shape(300, 200, 4'hF);
        out_ready = 1'b0;
        push(1, 1, 1'b1);
        wait_valid("t5_valid");
        for (int i = 0; i < 9; i++) begin
            in_x = 12'(i + 2); in_y = 12'(i + 2); in_valid = 1'b1;
            if (i < 8) model(i + 2, i + 2);
            cycle();
        end
        in_valid = 1'b0;
        check("t5_overflow", 32'(overflow), 32'd1);
        check("t5_pause", 32'(ena_pause), 32'd1);
        complete();
        out_ready = 1'b1;
        wait_done("t5");
        check("t5_overflow_sticky", 32'(overflow), 32'd1);
        begin_shape(50, 50, 4'hF);
        check("t5_overflow_cleared", 32'(overflow), 32'd0);
        complete();
        wait_done("t5_empty");

        // Asynchronous reset with a pixel held and entries queued.
        begin_shape(300, 200, 4'hF);
        out_ready = 1'b0;
        push(1, 2, 1'b1);
        push(3, 4, 1'b1);
        push(5, 6, 1'b1);
        wait_valid("t6_valid");
        #2 reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        prev_stall = 1'b0;
        cycle();
        reset = 1'b0;
        check("t6_rst_pause", 32'(ena_pause), 32'd0);
        check("t6_rst_xy", {8'd0, out_x, out_y}, 32'd0);
        out_ready = 1'b1;
        begin_shape(300, 200, 4'hF);
        complete();
        wait_done("t6_flushed");
        begin_shape(100, 50, 4'hF);
        sb.push_back({12'd103, 12'd52});
        sb.push_back({12'd97,  12'd52});
        sb.push_back({12'd97,  12'd48});
        sb.push_back({12'd103, 12'd48});
        push(3, 2, 1'b0);
        complete();
        wait_done("t6_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
